// File: rtl/water_box_tracker_pkg.sv
// water_box_pkg: level encodings and the count/direction to level classifier
package water_box_pkg;
  typedef logic [1:0] level_t;
  localparam level_t LVL_C = 2'b00;
  localparam level_t LVL_L = 2'b01;
  localparam level_t LVL_M = 2'b10;
  localparam level_t LVL_H = 2'b11;
  function automatic level_t classify(input int cnt, input logic dir, input int ul, input int um,
                                      input int uh, input int dl, input int dm, input int dh);
    int l, m, h;
    l = dir ? ul : dl;
    m = dir ? um : dm;
    h = dir ? uh : dh;
    return cnt >= h ? LVL_H : cnt >= m ? LVL_M : cnt >= l ? LVL_L : LVL_C;
  endfunction
endpackage

// File: rtl/water_box_tracker_if.sv
// water_box_tracker_if: pulse inputs and status outputs of the reservoir tracker
interface water_box_tracker_if import water_box_pkg::*; #(parameter int WIDTH = 3);
  logic fill, drain, clr_err;
  logic [WIDTH-1:0] count;
  logic direction, level_change, at_full, at_empty, overflow_err, underflow_err;
  level_t water_box;
  modport master(output fill, drain, clr_err,
                 input count, direction, water_box, level_change, at_full, at_empty, overflow_err, underflow_err);
  modport slave(input fill, drain, clr_err,
                output count, direction, water_box, level_change, at_full, at_empty, overflow_err, underflow_err);
endinterface

// File: rtl/water_box_tracker_settle_filter.sv
// water_box_settle_filter: registers the level, optionally after a stability window (WATER_BOX_SETTLE_EN)
module water_box_settle_filter import water_box_pkg::*; #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  level_t cand,
  output level_t level,
  output logic   level_change
);
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
`ifdef WATER_BOX_SETTLE_EN
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  logic [CW-1:0] cnt;
  level_t pend;
  logic fresh;
  assign fresh = cnt == '0 || cand != pend;
  // a differing candidate must be seen unchanged for SETTLE_CYCLES edges, committing on the next one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level <= LVL_C;
      level_change <= 1'b0;
      cnt <= '0;
      pend <= LVL_C;
    end else begin
      level_change <= cand != level && !fresh && cnt == CW'(SETTLE_CYCLES);
      level <= (cand != level && !fresh && cnt == CW'(SETTLE_CYCLES)) ? cand : level;
      pend <= cand;
      cnt <= cand == level ? '0 : fresh ? CW'(1) : cnt == CW'(SETTLE_CYCLES) ? '0 : cnt + 1'b1;
    end
`else
  // plain one-edge register of the candidate level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level <= LVL_C;
      level_change <= 1'b0;
    end else begin
      level <= cand;
      level_change <= cand != level;
    end
`endif
endmodule

// File: rtl/water_box_tracker.sv
// water_box_tracker: saturating fill/drain volume counter with hysteretic level output (optional WATER_BOX_SETTLE_EN)
module water_box_tracker import water_box_pkg::*; #(
  parameter int WIDTH = 3,
  parameter int MAX_COUNT = 7,
  parameter int UP_L = 1,
  parameter int UP_M = 3,
  parameter int UP_H = 7,
  parameter int DN_L = 1,
  parameter int DN_M = 5,
  parameter int DN_H = 7,
  parameter int SETTLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  water_box_tracker_if.slave bus
);
  if (MAX_COUNT > 2 ** WIDTH - 1 || !(UP_L < UP_M && UP_M < UP_H && UP_H <= MAX_COUNT) ||
      !(DN_L < DN_M && DN_M < DN_H && DN_H <= MAX_COUNT)) begin : g_bad_params
    $error("water_box_tracker thresholds or MAX_COUNT out of range");
  end
  logic [WIDTH-1:0] count_q;
  logic dir_q, ovf_q, unf_q, inc, dec, full, empty;
  level_t cand;
  // single-direction requests only; simultaneous fill and drain cancel out
  always_comb begin
    inc = bus.fill & ~bus.drain;
    dec = bus.drain & ~bus.fill;
    full = count_q == WIDTH'(MAX_COUNT);
    empty = count_q == '0;
    cand = classify(int'(count_q), dir_q, UP_L, UP_M, UP_H, DN_L, DN_M, DN_H);
  end
  // volume, direction and sticky errors; a new error beats clr_err
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_q <= '0;
      dir_q <= 1'b1;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      count_q <= inc && !full ? count_q + 1'b1 : dec && !empty ? count_q - 1'b1 : count_q;
      dir_q <= inc ? 1'b1 : dec ? 1'b0 : dir_q;
      ovf_q <= (inc & full) | (ovf_q & ~bus.clr_err);
      unf_q <= (dec & empty) | (unf_q & ~bus.clr_err);
    end
  water_box_settle_filter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_filt (
    .clk(clk),
    .rst(rst),
    .cand(cand),
    .level(bus.water_box),
    .level_change(bus.level_change)
  );
  assign bus.count = count_q;
  assign bus.direction = dir_q;
  assign bus.at_full = full;
  assign bus.at_empty = empty;
  assign bus.overflow_err = ovf_q;
  assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_water_box_tracker.sv
// tb_water_box_tracker: directed checks of the default tracker (settle sequence when WATER_BOX_SETTLE_EN)
module tb_water_box_tracker;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0;
  localparam int S = 4;
  localparam logic [1:0] UP [8] = '{0, 1, 1, 2, 2, 2, 2, 3};
  localparam logic [1:0] DN [8] = '{0, 1, 1, 1, 1, 2, 2, 3};
  water_box_tracker_if #(.WIDTH(3)) bus();
  water_box_tracker #(.SETTLE_CYCLES(S)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic f, input logic d, input logic c);
    bus.fill = f;
    bus.drain = d;
    bus.clr_err = c;
    @(posedge clk);
    #1;
  endtask
  task automatic lvl(input string tag, input logic [1:0] wb, input logic lc);
    chk({tag, "_wb"}, 32'(bus.water_box), 32'(wb));
    chk({tag, "_lc"}, 32'(bus.level_change), 32'(lc));
  endtask
  initial begin
    logic [1:0] prev, e;
    bus.fill = 0;
    bus.drain = 0;
    bus.clr_err = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_dir", 32'(bus.direction), 1);
    lvl("rst", 2'd0, 1'b0);
    chk("rst_empty", 32'(bus.at_empty), 1);
    chk("rst_full", 32'(bus.at_full), 0);
    chk("rst_ovf", 32'(bus.overflow_err), 0);
    chk("rst_unf", 32'(bus.underflow_err), 0);
`ifdef WATER_BOX_SETTLE_EN
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (8) step(0, 0, 0);
    lvl("st_base", 2'd1, 1'b0);
    step(1, 0, 0);
    chk("st_cnt3", 32'(bus.count), 3);
    step(0, 0, 0);
    lvl("st_w1", 2'd1, 1'b0);
    step(0, 1, 0);
    lvl("st_w2", 2'd1, 1'b0);
    for (int i = 0; i < S + 2; i++) begin
      step(0, 0, 0);
      lvl("st_abort", 2'd1, 1'b0);
    end
    step(1, 0, 0);
    for (int i = 1; i <= S; i++) begin
      step(0, 0, 0);
      lvl("st_wait", 2'd1, 1'b0);
    end
    step(0, 0, 0);
    lvl("st_commit", 2'd2, 1'b1);
    step(0, 0, 0);
    lvl("st_after", 2'd2, 1'b0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    #2 rst = 1;
    #1;
    lvl("st_rst", 2'd0, 1'b0);
    chk("st_rst_cnt", 32'(bus.count), 0);
    @(negedge clk) rst = 0;
    repeat (S + 3) step(0, 0, 0);
    lvl("st_rst_quiet", 2'd0, 1'b0);
`else
    prev = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      step(1, 0, 0);
      chk("fill_cnt", 32'(bus.count), 32'(k));
      lvl("fill", UP[k-1], UP[k-1] != prev);
      prev = UP[k-1];
    end
    chk("fill_full", 32'(bus.at_full), 1);
    chk("fill_nempty", 32'(bus.at_empty), 0);
    step(0, 0, 0);
    lvl("fill_top", 2'd3, 1'b1);
    prev = 2'd3;
    for (int j = 1; j <= 7; j++) begin
      step(0, 1, 0);
      e = j == 1 ? 2'd3 : DN[8-j];
      chk("drain_cnt", 32'(bus.count), 32'(7 - j));
      chk("drain_dir", 32'(bus.direction), 0);
      lvl("drain", e, e != prev);
      prev = e;
    end
    step(0, 0, 0);
    lvl("drain_bot", 2'd0, 1'b1);
    chk("drain_empty", 32'(bus.at_empty), 1);
    step(0, 1, 0);
    chk("unf_cnt", 32'(bus.count), 0);
    chk("unf_set", 32'(bus.underflow_err), 1);
    step(0, 1, 1);
    chk("unf_setwins", 32'(bus.underflow_err), 1);
    step(0, 0, 1);
    chk("unf_clr", 32'(bus.underflow_err), 0);
    repeat (5) step(1, 0, 0);
    step(0, 1, 0);
    chk("dn4_cnt", 32'(bus.count), 4);
    step(0, 0, 0);
    step(0, 0, 0);
    lvl("dn4", 2'd1, 1'b0);
    step(1, 0, 0);
    chk("turn_dir", 32'(bus.direction), 1);
    lvl("turn_hold", 2'd1, 1'b0);
    step(0, 0, 0);
    lvl("turn_up", 2'd2, 1'b1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    lvl("at3", 2'd1, 1'b0);
    step(1, 1, 0);
    chk("both_cnt", 32'(bus.count), 3);
    chk("both_dir", 32'(bus.direction), 0);
    lvl("both", 2'd1, 1'b0);
    step(0, 0, 0);
    lvl("both2", 2'd1, 1'b0);
    chk("both_ovf", 32'(bus.overflow_err), 0);
    repeat (4) step(1, 0, 0);
    chk("top_cnt", 32'(bus.count), 7);
    chk("top_ovf0", 32'(bus.overflow_err), 0);
    step(1, 0, 0);
    chk("ovf_cnt", 32'(bus.count), 7);
    chk("ovf_set", 32'(bus.overflow_err), 1);
    step(1, 0, 1);
    chk("ovf_setwins", 32'(bus.overflow_err), 1);
    step(0, 0, 1);
    chk("ovf_clr", 32'(bus.overflow_err), 0);
    chk("ovf_full", 32'(bus.at_full), 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
